// File: rtl/ucsbece154b_prefetch_pkg.sv
// Shared types and constants for the instruction prefetcher.
package ucsbece154b_prefetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH
  } state_e;

  // Byte distance between consecutive fetch words
  localparam int unsigned PC_INC = 4;

  localparam int unsigned DEF_NR_ENTRIES      = 4;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;

  // Bits needed to count up to the larger of the two credit limits
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_width(DEF_NR_ENTRIES, DEF_MAX_OUTSTANDING);

  typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/ucsbece154b_credit_cnt.sv
// Up/down credit counter with synchronous clear and parallel load.
// clr has priority over ld; simultaneous inc and dec cancel out.
module ucsbece154b_credit_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  // Counter register
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (inc && !dec) begin
      q <= q + W'(1);
    end else if (dec && !inc) begin
      q <= q - W'(1);
    end
  end

endmodule

// File: rtl/ucsbece154b_prefetcher.sv
// Instruction FIFO write-side producer: issues sequential word fetches,
// pushes in-order responses into the FIFO using a credit scheme, and drops
// responses that were in flight across a redirect.
// Optional: define PREFETCH_PERF_CNT_EN to add stall/drop perf counters.
module ucsbece154b_prefetcher
  import ucsbece154b_prefetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned NR_ENTRIES      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i,
  output logic                  req_valid_o,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  input  logic                  req_ready_i,
  input  logic                  rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] rsp_data_i,
  output logic                  push_o,
  output logic [DATA_WIDTH-1:0] push_data_o,
  input  logic                  fifo_pop_i,
  output logic                  busy_o
`ifdef PREFETCH_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           dropped_rsp_o
`endif
);

  localparam int unsigned CW = cnt_width(NR_ENTRIES, MAX_OUTSTANDING);
  localparam int unsigned SW = CW + 1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CW-1:0]         occ_q;
  logic [CW-1:0]         inflight_q;
  logic [CW-1:0]         drop_q;
  logic [CW-1:0]         drop_nxt;
  logic [SW-1:0]         drop_sum;
  logic                  accept;
  logic                  rsp_drop;
  logic                  rsp_good;

  // Request issue gated by FIFO credits and outstanding-request budget
  assign req_valid_o = (state_q == S_FETCH) && en_i && !flush_i &&
                       ((SW'(occ_q) + SW'(inflight_q)) < SW'(NR_ENTRIES)) &&
                       ((SW'(inflight_q) + SW'(drop_q)) < SW'(MAX_OUTSTANDING));
  assign req_addr_o  = pc_q;
  assign accept      = req_valid_o && req_ready_i;

  // Response classification: stale responses are consumed by pending drops
  assign rsp_drop    = rsp_valid_i && (drop_q != '0);
  assign rsp_good    = rsp_valid_i && (drop_q == '0) && (inflight_q != '0);
  assign push_o      = rsp_good && !flush_i;
  assign push_data_o = push_o ? rsp_data_i : '0;
  assign busy_o      = (inflight_q != '0) || (drop_q != '0);

  // On redirect every response still owed becomes a drop; the ones arriving
  // this cycle are consumed here and not carried forward
  assign drop_sum = SW'(drop_q) + SW'(inflight_q) + SW'(accept)
                  - SW'(rsp_good) - SW'(rsp_drop);
  assign drop_nxt = flush_i ? CW'(drop_sum) : (drop_q - CW'(rsp_drop));

  ucsbece154b_credit_cnt #(.W(CW)) u_occ (
    .clk    (clk),
    .clr    (rst || flush_i),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (push_o),
    .dec    (fifo_pop_i),
    .q      (occ_q)
  );

  ucsbece154b_credit_cnt #(.W(CW)) u_inflight (
    .clk    (clk),
    .clr    (rst || flush_i),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (accept),
    .dec    (rsp_good),
    .q      (inflight_q)
  );

  ucsbece154b_credit_cnt #(.W(CW)) u_drop (
    .clk    (clk),
    .clr    (rst),
    .ld     (flush_i),
    .ld_val (CW'(drop_sum)),
    .inc    (1'b0),
    .dec    (rsp_drop),
    .q      (drop_q)
  );

  // Fetch PC and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      if (flush_i) begin
        pc_q <= flush_pc_i;
      end else if (accept) begin
        pc_q <= pc_q + ADDR_WIDTH'(PC_INC);
      end
      case (state_q)
        S_IDLE: begin
          if (en_i) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (flush_i) begin
            if ((inflight_q != '0) || accept) state_q <= S_FLUSH;
          end else if (!en_i && (inflight_q == '0)) begin
            state_q <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (drop_nxt == '0) state_q <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef PREFETCH_PERF_CNT_EN
  // Saturating stall and dropped-response counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_o <= '0;
      dropped_rsp_o  <= '0;
    end else begin
      if ((state_q == S_FETCH) && en_i && !req_valid_o && (stall_cycles_o != '1))
        stall_cycles_o <= stall_cycles_o + 32'd1;
      if ((rsp_drop || (rsp_good && flush_i)) && (dropped_rsp_o != '1))
        dropped_rsp_o <= dropped_rsp_o + 32'd1;
    end
  end
`endif

  // A response with nothing owed is a memory protocol violation
  rsp_protocol_a: assert property (@(posedge clk) disable iff (rst)
    !(rsp_valid_i && (drop_q == '0) && (inflight_q == '0)));

  // Credits guarantee the FIFO can never be overfilled
  credit_bound_a: assert property (@(posedge clk) disable iff (rst)
    ((SW'(occ_q) + SW'(inflight_q)) <= SW'(NR_ENTRIES)));

endmodule
